// File: rtl/sd_multi_region_loader_pkg.sv
// Shared definitions for the multi-region SD loader.
//   state_t     : loader FSM states
//   SEC_WORDS   : 16-bit words in one 512-byte SD sector
//   out_w_legal : accepted DDR beat widths (16/32/64)
//   idx_w       : region index width, never below 1 bit
package sd_load_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_REG,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_SEC_END,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    localparam int SEC_WORDS = 256;

    function automatic bit out_w_legal(input int w);
        return (w == 16) || (w == 32) || (w == 64);
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sd_multi_region_loader_if.sv
// SD read side and DDR write side of the loader, bundled.
//   master : the loader (issues sector reads, drives DDR beats)
//   slave  : the SD controller / DDR port side
interface sd_multi_region_loader_if #(
    parameter int OUT_W = 32
);
    logic             rd_busy;
    logic             sd_rd_val_en;
    logic [15:0]      sd_rd_val_data;
    logic             rd_start_en;
    logic [31:0]      rd_sec_addr;
    logic             ddr_wr_en;
    logic [OUT_W-1:0] ddr_wr_data;

    modport master (
        input  rd_busy, sd_rd_val_en, sd_rd_val_data,
        output rd_start_en, rd_sec_addr, ddr_wr_en, ddr_wr_data
    );

    modport slave (
        output rd_busy, sd_rd_val_en, sd_rd_val_data,
        input  rd_start_en, rd_sec_addr, ddr_wr_en, ddr_wr_data
    );
endinterface

// File: rtl/sd_word_packer.sv
// Packs 16-bit words into OUT_W-bit beats, lane 0 in bits [15:0].
//   accept/word : write word into the next lane; a full beat is emitted
//                 one cycle after its last lane is filled
//   flush       : emit a partially filled beat, upper lanes zero
//   clear       : drop any partial content
//   wr_en/wr_data : registered beat output, one-cycle strobe
//   partial     : at least one lane holds data not yet emitted
module sd_word_packer #(
    parameter int OUT_W = 32
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic [15:0]      word,
    input  logic             flush,
    input  logic             clear,
    output logic             wr_en,
    output logic [OUT_W-1:0] wr_data,
    output logic             partial
);
    localparam int PACK = OUT_W / 16;
    localparam int FW   = (PACK > 1) ? $clog2(PACK) : 1;

    logic [PACK-1:0][15:0] lanes_q, lanes_d;
    logic [FW-1:0]         fill_q;
    logic                  last_lane;

    assign last_lane = (fill_q == FW'(PACK - 1));
    assign partial   = (fill_q != '0);

    // Lanes with the incoming word merged in; used both to store and to
    // emit a beat that the current word completes.
    always_comb begin
        lanes_d = lanes_q;
        for (int l = 0; l < PACK; l++)
            if (fill_q == FW'(l)) lanes_d[l] = word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
            fill_q  <= '0;
            wr_en   <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                lanes_q <= '0;
                fill_q  <= '0;
            end else if (accept) begin
                if (last_lane) begin
                    wr_en   <= 1'b1;
                    wr_data <= lanes_d;
                    lanes_q <= '0;
                    fill_q  <= '0;
                end else begin
                    lanes_q <= lanes_d;
                    fill_q  <= fill_q + 1'b1;
                end
            end else if (flush && partial) begin
                wr_en   <= 1'b1;
                wr_data <= lanes_q;
                lanes_q <= '0;
                fill_q  <= '0;
            end
        end
    end

endmodule

// File: rtl/sd_multi_region_loader.sv
// Loads up to REGION_NUM parameter regions from SD sectors into DDR.
//   clk, rst_n        : clock, async active-low reset
//   start             : begin at region 0 (accepted in IDLE/ERR only)
//   region_sec_base   : per-region start sector, [r*32 +: 32]
//   region_word_num   : per-region 16-bit word count, 0 = skip
//   bus (master)      : SD read request/data in, DDR beat out
//   region_idx        : region being loaded
//   word_cnt          : words accepted in the current region
//   busy/done/err     : status; err is sticky until the next start
module sd_multi_region_loader
    import sd_load_pkg::*;
#(
    parameter int REGION_NUM  = 4,
    parameter int OUT_W       = 32,
    parameter int SEC_WORDS   = sd_load_pkg::SEC_WORDS,
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 2000000,
    localparam int IDX_W      = idx_w(REGION_NUM)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [REGION_NUM*32-1:0]    region_sec_base,
    input  logic [REGION_NUM*CNT_W-1:0] region_word_num,
    sd_multi_region_loader_if.master    bus,
    output logic [IDX_W-1:0]            region_idx,
    output logic [CNT_W-1:0]            word_cnt,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    if (!out_w_legal(OUT_W) || (SEC_WORDS % (OUT_W / 16)) != 0) begin : g_bad_cfg
        $error("sd_multi_region_loader: unsupported OUT_W/SEC_WORDS");
    end

    state_t           state_q, state_d;
    logic [31:0]      base_q, sec_cnt;
    logic [CNT_W-1:0] num_q;
    logic [TMO_W-1:0] tmo_q;
    logic [31:0]      cfg_base;
    logic [CNT_W-1:0] cfg_num;
    logic             go_first, load_cfg, next_reg, sec_inc, pk_flush;
    logic             waiting, accept, tmo_hit, last_reg, pk_partial;

    // Configuration of the region currently addressed by region_idx.
    always_comb begin
        cfg_base = '0;
        cfg_num  = '0;
        for (int r = 0; r < REGION_NUM; r++) begin
            if (region_idx == IDX_W'(r)) begin
                cfg_base = region_sec_base[r*32 +: 32];
                cfg_num  = region_word_num[r*CNT_W +: CNT_W];
            end
        end
    end

    assign waiting  = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
    assign accept   = waiting && bus.sd_rd_val_en && (word_cnt < num_q);
    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign last_reg = (region_idx == IDX_W'(REGION_NUM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        go_first = 1'b0;
        load_cfg = 1'b0;
        next_reg = 1'b0;
        sec_inc  = 1'b0;
        pk_flush = 1'b0;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d  = S_LOAD_REG;
                    go_first = 1'b1;
                end
            end
            S_LOAD_REG: begin
                if (cfg_num == '0) begin
                    if (last_reg) state_d = S_DONE;
                    else          next_reg = 1'b1;
                end else begin
                    load_cfg = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (bus.rd_busy)  state_d = S_WAIT_LO;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_WAIT_LO: begin
                if (!bus.rd_busy) state_d = S_SEC_END;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_SEC_END: begin
                if (word_cnt < num_q) begin
                    sec_inc = 1'b1;
                    state_d = S_ISSUE;
                end else if (pk_partial) begin
                    state_d = S_FLUSH;
                end else if (last_reg) begin
                    state_d = S_DONE;
                end else begin
                    next_reg = 1'b1;
                    state_d  = S_LOAD_REG;
                end
            end
            S_FLUSH: begin
                pk_flush = 1'b1;
                if (last_reg) state_d = S_DONE;
                else begin
                    next_reg = 1'b1;
                    state_d  = S_LOAD_REG;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_idx <= '0;
            base_q     <= '0;
            num_q      <= '0;
            word_cnt   <= '0;
            sec_cnt    <= '0;
            tmo_q      <= '0;
            err        <= 1'b0;
        end else begin
            if (go_first)      region_idx <= '0;
            else if (next_reg) region_idx <= region_idx + 1'b1;

            if (load_cfg) begin
                base_q   <= cfg_base;
                num_q    <= cfg_num;
                word_cnt <= '0;
                sec_cnt  <= '0;
            end else begin
                if (accept)  word_cnt <= word_cnt + 1'b1;
                if (sec_inc) sec_cnt  <= sec_cnt + 32'd1;
            end

            // Restart the wait budget whenever the state moves or data shows up.
            if ((state_d != state_q) || bus.sd_rd_val_en) tmo_q <= '0;
            else if (waiting)                             tmo_q <= tmo_q + 1'b1;

            if (go_first)              err <= 1'b0;
            else if (state_d == S_ERR) err <= 1'b1;
        end
    end

    // Address is a pure function of held registers, so it stays stable
    // from the request through the end of the sector.
    assign bus.rd_sec_addr = base_q + sec_cnt;
    assign bus.rd_start_en = (state_q == S_ISSUE);
    assign busy = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign done = (state_q == S_DONE);

    sd_word_packer #(.OUT_W(OUT_W)) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .accept  (accept),
        .word    (bus.sd_rd_val_data),
        .flush   (pk_flush),
        .clear   (go_first | load_cfg),
        .wr_en   (bus.ddr_wr_en),
        .wr_data (bus.ddr_wr_data),
        .partial (pk_partial)
    );

endmodule

// File: doc/sd_multi_region_loader.md
Name: sd_multi_region_loader

Overview:
- Sequences SD-card sector reads for up to REGION_NUM independent parameter regions and streams the payload to the DDR3 write port.
- Each region has its own start sector and 16-bit word count.
- Packs 16-bit SD words into OUT_W-bit DDR beats and drops the sector tail beyond each region's word count.
- Adds a busy-handshake timeout with error reporting, plus per-region progress outputs.
- Sits between sd_ctrl_top (read side) and ddr3_top (wr_en/wrdata) in the model-loading top.

Parameters:
- REGION_NUM, 4: number of regions; region_idx width is IDX_W = max(1, clog2(REGION_NUM)).
- OUT_W, 32: DDR beat width; legal values 16/32/64; PACK = OUT_W/16.
- SEC_WORDS, 256: 16-bit words per 512-byte sector.
- CNT_W, 24: width of word counts.
- TIMEOUT_CYC, 2000000: maximum cycles spent in a wait-for-busy state.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins loading from region 0; ignored while busy=1.
- region_sec_base  in  REGION_NUM*32  start sector of region r, in bits [r*32 +: 32].
- region_word_num  in  REGION_NUM*CNT_W  16-bit word count of region r; 0 means skip the region.
- rd_busy  in  1  from sd_ctrl_top.
- sd_rd_val_en  in  1  SD read-data valid.
- sd_rd_val_data  in  16  SD read data.
- rd_start_en  out  1  one-cycle sector read request.
- rd_sec_addr  out  32  sector address; held stable from the request until rd_busy falls.
- ddr_wr_en  out  1  DDR write strobe, one cycle per beat.
- ddr_wr_data  out  OUT_W  packed beat.
- region_idx  out  IDX_W  region currently being loaded.
- word_cnt  out  CNT_W  words accepted so far in the current region.
- busy  out  1  high from the cycle after an accepted start until the cycle DONE or ERR is entered.
- done  out  1  one-cycle pulse when all regions have completed.
- err  out  1  sticky timeout flag; cleared by the next accepted start.

Behaviour:
- Reset values: every output is 0 and the FSM is in IDLE. Reset asserted mid-operation aborts immediately; no flush is performed.
- Region configuration inputs are sampled when the region is entered (LOAD_REG); they must be stable until the region completes.
- FSM states: IDLE, LOAD_REG, ISSUE, WAIT_HI, WAIT_LO, SEC_END, FLUSH, DONE, ERR.
  - IDLE: on start go to LOAD_REG with region_idx=0 and err cleared.
  - LOAD_REG:
    - If word_num==0, advance region_idx, or go to DONE if this is the last region.
    - Otherwise latch base and word_num, clear word_cnt and the sector counter, then go to ISSUE.
  - ISSUE: rd_start_en=1 for exactly one cycle with rd_sec_addr = base + sec_cnt (32-bit wrap); then WAIT_HI.
  - WAIT_HI: wait for rd_busy=1, then WAIT_LO. If TIMEOUT_CYC cycles pass, go to ERR.
  - WAIT_LO: accept data, wait for rd_busy=0, then SEC_END. Timeout goes to ERR.
    - The timeout counter is cleared on every state change and on every sd_rd_val_en.
  - SEC_END:
    - If word_cnt < word_num: sec_cnt+1, then ISSUE.
    - Else if the pack register holds a partial beat: FLUSH.
    - Else: next region (LOAD_REG) or DONE.
  - FLUSH: emit the partial beat, zero-padded in its upper lanes; then next region or DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: err=1 and busy=0; hold until the next start.
- Data path:
  - A sd_rd_val_en with word_cnt < word_num is accepted and placed into pack lane (word_cnt mod PACK); lane 0 is bits [15:0], little-endian.
  - Words arriving after the count is reached are discarded. So is any sd_rd_val_en seen outside WAIT_HI/WAIT_LO.
  - When the last lane is filled, ddr_wr_en=1 on the next cycle with the complete beat. This gives 1-cycle latency from the final accepted word.
  - The pack register clears after each emitted beat. Beats never straddle regions.
- Sectors per region = ceil(word_num / SEC_WORDS). Total writes per region = ceil(word_num / PACK).
- A start asserted in the same cycle as the DONE→IDLE transition is ignored; start is accepted only in IDLE or ERR.

Decomposition:
- Shared package sd_load_pkg holds:
  - the state enum;
  - SEC_WORDS;
  - legal OUT_W values;
  - the IDX_W derivation function.
- One sub-module, sd_word_packer: a 16→OUT_W lane packer with accept, flush and clear inputs and a wr_en/data output. The FSM stays in the top of this block.

Test Plan:
- OUT_W=16, one active region (base=100, num=300), others 0:
  - rd_sec_addr goes 100 then 101;
  - exactly 300 ddr_wr_en pulses, data equal to input order;
  - the 212 tail words are dropped;
  - then a single done pulse.
- OUT_W=32, region base=7, num=5:
  - 3 writes: {w1,w0}, {w3,w2}, {16'h0,w4};
  - word_cnt ends at 5.
- REGION_NUM=4 with num={0,512,0,1}:
  - regions 0 and 2 are skipped;
  - sectors requested are base1, base1+1, base3;
  - region_idx is observed as 1 then 3;
  - 513 words are accepted in total (OUT_W=16).
- rd_busy never rises after rd_start_en (TIMEOUT_CYC=100):
  - ERR is reached at 100 cycles, err=1, busy=0, no ddr writes;
  - a new start clears err and reissues the read.
- A start pulse mid-load is ignored with no state change. Then rst_n is pulled low mid-sector: all outputs go to 0 at once, and no write or done pulse follows reset release.
